mag_comparator_seq: RTL and testbench
=====================================

# mag_comparator_seq

Parametrised, iterative magnitude comparator for WIDTH-bit operands. It compares DIGIT bits per clock, most-significant digit first, and stops early at the first differing digit. It supports unsigned and two's-complement modes and uses a start/busy/done handshake. It is the multi-bit, sequential successor to the team's 2-bit gate-level comparator and is intended for datapaths where a full-width combinational compare is too deep.

## Interface
- WIDTH, 8: operand width in bits; must be ≥ 2.
- DIGIT, 2: bits compared per cycle; WIDTH % DIGIT must be 0, otherwise elaboration fails.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request a compare; accepted only when busy = 0.
- a  in  WIDTH  operand A; sampled on the accepted start edge.
- b  in  WIDTH  operand B; sampled on the accepted start edge.
- signed_mode  in  1  1 = two's complement, 0 = unsigned; sampled with the operands.
- busy  out  1  high while a compare is in progress.
- done  out  1  one-cycle pulse when the result becomes valid.
- a_eq_b  out  1  result flag: A = B.
- a_gt_b  out  1  result flag: A > B.
- a_lt_b  out  1  result flag: A < B.

## Operation
- NDIG = WIDTH/DIGIT. Digit index i = 0 is the most-significant digit.
- States:
  - IDLE: busy = 0.
  - CMP: busy = 1; a digit counter runs 0..NDIG-1.
  - DONE: single cycle; done = 1, busy = 0.
- IDLE or DONE, start = 1 → CMP:
  - latch a, b and signed_mode;
  - clear all three result flags;
  - reset the digit counter to 0.
- Signed mode: invert the MSB of both latched operands (offset-binary). The unsigned compare then yields the signed order.
- In CMP, each edge compares digit i of A against digit i of B:
  - digits differ → set gt or lt, go to DONE;
  - digits equal and i = NDIG-1 → set eq, go to DONE;
  - otherwise increment i.
- DONE → IDLE, unless start is asserted in that cycle, which is accepted immediately (back-to-back compares).
- After done, exactly one flag is 1. Flags hold until the next accepted start.
- start while busy = 1 is ignored. Latched operands are not disturbed.
- Changes on a, b or signed_mode outside an accepted start edge have no effect.

## Timing
- Reset, at the next edge with rst = 1, from any state:
  - state = IDLE, counter = 0;
  - busy = 0, done = 0, a_eq_b = a_gt_b = a_lt_b = 0.
  - rst has priority over start.
- Let the start be accepted at edge E0:
  - busy = 1 from E0;
  - first differing digit at index i → done = 1 for the single cycle after edge E(i+1), with flags valid in that same cycle.
- Equal operands: done after E(NDIG). This is the worst-case latency of NDIG cycles.
- Best-case latency: 1 cycle (MSD differs).
- busy falls at the same edge done rises.
- rst mid-compare aborts with no done pulse.
- Flags are registered outputs; no combinational path from inputs to outputs.

## Structure
- Package mag_cmp_pkg contains:
  - state enum {IDLE, CMP, DONE};
  - function clog2 for the counter width;
  - the NDIG derivation.
- Sub-module cmp_digit #(DIGIT): combinational DIGIT-bit comparator with outputs eq and gt (lt = ~eq & ~gt). It is instantiated once and fed by a digit mux indexed by the counter.
- Top level holds the FSM, operand registers, counter and flag registers.

## Test plan
Configuration for all scenarios: WIDTH = 8, DIGIT = 2.
- Unsigned, a = 0xA5, b = 0x35, start at E0 → done high in the cycle after E1, a_gt_b = 1, others 0.
- a = b = 0x3C → busy for 4 cycles, done after E4, a_eq_b = 1.
- a = 0xFF, b = 0x01:
  - signed_mode = 1 → a_lt_b = 1 after E1;
  - signed_mode = 0 → a_gt_b = 1 after E1.
- a = 0x34, b = 0x35 (differ only in the LSD) → done after E4, a_lt_b = 1.
- start with a = 0x10, b = 0x20, then at E2 a second start with a = 0xF0, b = 0x00 while busy → the second start is ignored; result is a_lt_b = 1.
- Control corner cases:
  - rst at E1 during a compare → at E2: busy, done and flags all 0, state IDLE.
  - start asserted in the done cycle → new compare accepted; busy = 1 in the next cycle, flags cleared.

Source files
------------

// File: rtl/mag_cmp_pkg.sv
// Shared types and elaboration helpers for the iterative magnitude comparator.
package mag_cmp_pkg;

  // Controller states: waiting, walking digits MSD-first, result pulse.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Ceiling log2, used to size the digit counter.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Number of DIGIT-wide digits in a WIDTH-bit operand.
  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/cmp_digit.sv
// Combinational DIGIT-bit unsigned comparator; "less than" is implied by !eq && !gt.
module cmp_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  output logic             eq,
  output logic             gt
);

  assign eq = (a == b);
  assign gt = (a > b);

endmodule

// File: rtl/mag_comparator_seq.sv
// Iterative MSD-first magnitude comparator with early exit and a
// start/busy/done handshake. Signed operands are mapped to offset-binary
// at capture so a single unsigned digit comparator serves both modes.
module mag_comparator_seq
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             a_eq_b,
  output logic             a_gt_b,
  output logic             a_lt_b
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = (NDIG > 1) ? clog2(NDIG) : 1;

  typedef logic [CW-1:0] cnt_t;
  localparam cnt_t LAST_DIG = cnt_t'(NDIG - 1);

  // Reject illegal geometries at elaboration time.
  if (WIDTH < 2) begin : g_bad_width
    $error("mag_comparator_seq: WIDTH must be >= 2");
  end
  if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
    $error("mag_comparator_seq: WIDTH must be a multiple of DIGIT");
  end

  state_e           state_q;
  cnt_t             cnt_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             busy_q, done_q;
  logic             eq_q, gt_q, lt_q;

  logic [DIGIT-1:0] a_dig, b_dig;
  logic             dig_eq, dig_gt;
  logic             accept;

  // A start is honoured whenever no compare is in flight (IDLE or DONE).
  assign accept = start && (state_q != CMP);

  // Capture operands on an accepted start, folding signed mode into the MSB.
  // NOTE: operand registers carry no reset; nothing observes them until a
  // start has loaded them, and the flag/busy registers gate all outputs.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= {a[WIDTH-1] ^ signed_mode, a[WIDTH-2:0]};
      b_q <= {b[WIDTH-1] ^ signed_mode, b[WIDTH-2:0]};
    end
  end

  // Select the digit pointed to by the counter; digit 0 is the MSD.
  // NOTE: defaults assigned first so no path leaves the outputs unassigned,
  // which would otherwise infer latches.
  always_comb begin
    a_dig = '0;
    b_dig = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (cnt_q == cnt_t'(i)) begin
        a_dig = a_q[WIDTH-1-i*DIGIT -: DIGIT];
        b_dig = b_q[WIDTH-1-i*DIGIT -: DIGIT];
      end
    end
  end

  cmp_digit #(
    .DIGIT (DIGIT)
  ) u_cmp_digit (
    .a  (a_dig),
    .b  (b_dig),
    .eq (dig_eq),
    .gt (dig_gt)
  );

  // Controller: state, digit counter and all registered outputs.
  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= CMP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            eq_q    <= 1'b0;
            gt_q    <= 1'b0;
            lt_q    <= 1'b0;
          end else begin
            state_q <= IDLE;
          end
        end
        CMP: begin
          if (!dig_eq) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            gt_q    <= dig_gt;
            lt_q    <= !dig_gt;
          end else if (cnt_q == LAST_DIG) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            eq_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + cnt_t'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign a_eq_b = eq_q;
  assign a_gt_b = gt_q;
  assign a_lt_b = lt_q;

endmodule

// File: tb/tb_mag_comparator_seq.sv
// Scoreboard bench for mag_comparator_seq (WIDTH = 8, DIGIT = 2).
module tb_mag_comparator_seq;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;

  typedef struct {
    logic [2:0] flags;  // {eq, gt, lt}
    int         lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             signed_mode = 1'b0;
  logic             busy, done, a_eq_b, a_gt_b, a_lt_b;

  exp_t sb[$];
  exp_t last_exp;
  int   n_checks = 0;
  int   n_errors = 0;

  mag_comparator_seq #(
    .WIDTH (WIDTH),
    .DIGIT (DIGIT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
    .signed_mode (signed_mode),
    .busy        (busy),
    .done        (done),
    .a_eq_b      (a_eq_b),
    .a_gt_b      (a_gt_b),
    .a_lt_b      (a_lt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: order from a plain integer compare, latency from first differing digit.
  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y, input logic sm);
    exp_t e;
    logic found;
    logic gt, lt;
    e.lat = NDIG;
    found = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!found && (x[WIDTH-1-i*DIGIT -: DIGIT] != y[WIDTH-1-i*DIGIT -: DIGIT])) begin
        e.lat = i + 1;
        found = 1'b1;
      end
    end
    gt = sm ? ($signed(x) > $signed(y)) : (x > y);
    lt = sm ? ($signed(x) < $signed(y)) : (x < y);
    e.flags = {!gt && !lt, gt, lt};
    return e;
  endfunction

  // Drive a start, step through the accepting edge, then scramble inputs.
  task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic sm);
    sb.push_back(model(av, bv, sm));
    a = av;
    b = bv;
    signed_mode = sm;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    signed_mode = 1'($urandom);
    check("busy_on_accept", 32'(busy), 32'd1);
    check("flags_cleared", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'd0);
  endtask

  // Wait (bounded) for done, then score latency and flags.
  task automatic finish_cmp(input int elapsed);
    int n;
    exp_t e;
    n = elapsed;
    while (!done && n < 4 * NDIG) begin
      @(posedge clk);
      #1;
      n++;
    end
    e = sb.pop_front();
    last_exp = e;
    check("done_seen", 32'(done), 32'd1);
    check("latency", 32'(n), 32'(e.lat));
    check("flags", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'(e.flags));
    check("busy_low_in_done", 32'(busy), 32'd0);
  endtask

  // One cycle later: done has dropped, flags hold, controller idle.
  task automatic hold_check();
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
    check("flags_hold", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'(last_exp.flags));
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  task automatic run(input logic [7:0] av, input logic [7:0] bv, input logic sm);
    launch(av, bv, sm);
    finish_cmp(0);
    hold_check();
  endtask

  initial begin
    int pulses;

    // Reset state
    rst = 1'b1;
    start = 1'b1;  // reset must win over start
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_flags", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'd0);
    rst = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_rst", 32'(busy), 32'd0);

    // Directed cases
    run(8'hA5, 8'h35, 1'b0);  // MSD differs, gt, latency 1
    run(8'h3C, 8'h3C, 1'b0);  // equal, latency 4
    run(8'hFF, 8'h01, 1'b1);  // signed: -1 < 1
    run(8'hFF, 8'h01, 1'b0);  // unsigned: 255 > 1
    run(8'h34, 8'h35, 1'b0);  // LSD differs, latency 4
    run(8'h80, 8'h80, 1'b1);  // signed equal at most-negative
    run(8'h7F, 8'h80, 1'b1);  // signed extremes: 127 > -128

    // start while busy is ignored
    launch(8'h10, 8'h20, 1'b0);
    @(posedge clk);
    #1;                          // after E1
    check("still_busy_e1", 32'(busy), 32'd1);
    a = 8'hF0;
    b = 8'h00;
    signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;                          // after E2
    start = 1'b0;
    finish_cmp(2);
    hold_check();

    // Reset mid-compare aborts with no done pulse
    launch(8'h3C, 8'h3C, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_front());
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_flags", 32'({a_eq_b, a_gt_b, a_lt_b}), 32'd0);
    pulses = 0;
    repeat (2 * NDIG) begin
      @(posedge clk);
      #1;
      if (done) pulses++;
    end
    check("no_done_after_abort", 32'(pulses), 32'd0);

    // Back-to-back: start asserted during the done cycle
    launch(8'h5A, 8'h5B, 1'b0);
    finish_cmp(0);
    launch(8'hC0, 8'h40, 1'b1);
    finish_cmp(0);
    hold_check();

    // Random mix
    for (int k = 0; k < 24; k++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = (k % 4 == 0) ? ra : 8'($urandom);
      if (k % 5 == 1) rb = {ra[7:2], 2'($urandom)};
      run(ra, rb, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
